// File: rtl/axis_frame_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_frame_arbiter: frame-granular round-robin arbiter onto one AXI-Stream
// output, with grant index, SOF pulse and per-frame beat count. Rev 1.0
// ----------------------------------------------------------------------------
module axis_frame_arbiter #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          s_valid,
  output logic [N_IN-1:0]          s_ready,
  input  logic [N_IN-1:0]          s_last,
  input  logic [N_IN*DATA_W-1:0]   s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [DATA_W-1:0]        m_data,
  output logic                     grant_vld,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     m_sof,
  output logic [15:0]              beat_cnt
);

  // One extra bit so rr_ptr + k (k <= N_IN) never overflows before the wrap.
  localparam int CW = IDX_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_first;

  logic              w_locked;
  logic              w_accept;
  logic              w_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [CW-1:0]     w_cand;
  logic [DATA_W-1:0] w_data_arr [N_IN];

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign w_data_arr[gi] = s_data[gi*DATA_W +: DATA_W];
  end

  assign w_locked = (r_state == ST_LOCKED);

  // Rotating search starting just after the last granted input.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N_IN; k++) begin
      w_cand = {1'b0, r_rr_ptr} + CW'(k);
      if (w_cand >= CW'(N_IN)) begin
        w_cand = w_cand - CW'(N_IN);
      end
      if (!w_found && s_valid[w_cand[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_sel_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  // Zero-latency pass-through of the locked input.
  always_comb begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    s_ready = '0;
    if (w_locked) begin
      m_valid            = s_valid[grant_idx];
      m_last             = s_last[grant_idx];
      m_data             = w_data_arr[grant_idx];
      s_ready[grant_idx] = m_ready;
    end
  end

  assign w_accept = m_valid & m_ready;
  assign m_sof    = m_valid & r_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      grant_vld <= 1'b0;
      grant_idx <= '0;
      r_rr_ptr  <= IDX_W'(N_IN - 1);
      r_first   <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state   <= ST_LOCKED;
            grant_vld <= 1'b1;
            grant_idx <= w_sel_idx;
            r_first   <= 1'b1;
            beat_cnt  <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_accept) begin
            r_first <= 1'b0;
            if (m_last) begin
              // grant_idx is left untouched so the last owner stays visible.
              r_state   <= ST_IDLE;
              grant_vld <= 1'b0;
              r_rr_ptr  <= grant_idx;
              beat_cnt  <= '0;
            end else if (beat_cnt != 16'hFFFF) begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axis_frame_arbiter: directed scenarios against a frame-level arbiter model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_axis_frame_arbiter;

  localparam int N_IN   = 4;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_IN-1:0]        s_valid = '0;
  logic [N_IN-1:0]        s_ready;
  logic [N_IN-1:0]        s_last = '0;
  logic [N_IN*DATA_W-1:0] s_data = '0;
  logic                   m_valid;
  logic                   m_ready = 1'b1;
  logic                   m_last;
  logic [DATA_W-1:0]      m_data;
  logic                   grant_vld;
  logic [1:0]             grant_idx;
  logic                   m_sof;
  logic [15:0]            beat_cnt;

  axis_frame_arbiter #(.N_IN(N_IN), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data),
    .grant_vld(grant_vld), .grant_idx(grant_idx), .m_sof(m_sof), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sources: one beat queue per input, entry = {last, data}.
  logic [32:0]     srcq [N_IN][$];
  logic [N_IN-1:0] gap = '0;
  logic [N_IN-1:0] hs_vec = '0;

  // Frame-level model state.
  logic            started = 1'b0;
  logic            mdl_locked = 1'b0;
  int              mdl_g = 0;
  int              mdl_ptr = N_IN - 1;
  logic            mdl_first = 1'b0;
  int              mdl_cnt = 0;
  int              grant_log[$];

  // Observed output beats.
  logic [33:0]     out_log[$];
  int              out_cyc[$];
  int              sof_cnt = 0;
  int              cyc = 0;

  logic [33:0]     exp_out[$];
  int              exp_grants[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Winner = requester with the smallest rotational distance past the pointer.
  function automatic int pick(input int ptr, input logic [N_IN-1:0] v);
    int best, bestd, d;
    best  = 0;
    bestd = N_IN;
    for (int i = 0; i < N_IN; i++) begin
      if (v[i]) begin
        d = (i - ptr - 1 + 2 * N_IN) % N_IN;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_locked <= 1'b0;
      mdl_g      <= 0;
      mdl_ptr    <= N_IN - 1;
      mdl_first  <= 1'b0;
      mdl_cnt    <= 0;
      started    <= 1'b1;
    end else if (!mdl_locked) begin
      if (s_valid != '0) begin
        mdl_g      <= pick(mdl_ptr, s_valid);
        mdl_locked <= 1'b1;
        mdl_first  <= 1'b1;
        mdl_cnt    <= 0;
        grant_log.push_back(pick(mdl_ptr, s_valid));
      end
    end else if (s_valid[mdl_g] && m_ready) begin
      mdl_first <= 1'b0;
      if (s_last[mdl_g]) begin
        mdl_locked <= 1'b0;
        mdl_ptr    <= mdl_g;
        mdl_cnt    <= 0;
      end else if (mdl_cnt < 65535) begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("grant_vld", grant_vld, mdl_locked);
      chk("grant_idx", grant_idx, mdl_g);
      chk("beat_cnt", beat_cnt, mdl_cnt);
      chk("m_valid", m_valid, mdl_locked && s_valid[mdl_g]);
      chk("m_last", m_last, mdl_locked && s_last[mdl_g]);
      chk("m_sof", m_sof, mdl_locked && s_valid[mdl_g] && mdl_first);
      chk("s_ready", s_ready, (mdl_locked && m_ready) ? (64'd1 << mdl_g) : 64'd0);
      if (mdl_locked && s_valid[mdl_g])
        chk("m_data", m_data, s_data[mdl_g*DATA_W +: DATA_W]);
    end
    hs_vec <= s_valid & s_ready;
    if (m_valid && m_ready) begin
      out_log.push_back({m_sof, m_last, m_data});
      out_cyc.push_back(cyc);
    end
    if (m_sof) sof_cnt <= sof_cnt + 1;
    cyc <= cyc + 1;
  end

  task automatic drive();
    logic [32:0] e;
    for (int i = 0; i < N_IN; i++) begin
      if (srcq[i].size() > 0 && !gap[i]) begin
        e = srcq[i][0];
        s_valid[i] = 1'b1;
        s_last[i]  = e[32];
        s_data[i*DATA_W +: DATA_W] = e[31:0];
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
        s_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_IN; i++)
      if (hs_vec[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic push(input int i, input logic [31:0] d, input logic l);
    srcq[i].push_back({l, d});
  endtask

  task automatic exp_beat(input logic sof, input logic last, input logic [31:0] d);
    exp_out.push_back({sof, last, d});
  endtask

  function automatic logic busy();
    logic b;
    b = grant_vld;
    for (int i = 0; i < N_IN; i++) if (srcq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    if (busy()) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic check_logs(input string tag, input int ob, input int gb);
    chk({tag, "_nbeats"}, out_log.size() - ob, exp_out.size());
    for (int k = 0; k < exp_out.size(); k++)
      if (ob + k < out_log.size())
        chk($sformatf("%s_beat%0d", tag, k), out_log[ob + k], exp_out[k]);
    chk({tag, "_ngrants"}, grant_log.size() - gb, exp_grants.size());
    for (int k = 0; k < exp_grants.size(); k++)
      if (gb + k < grant_log.size())
        chk($sformatf("%s_grant%0d", tag, k), grant_log[gb + k], exp_grants[k]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ob, gb, sb;
    logic [31:0] d;

    // Reset values.
    cycle(); cycle(); cycle();
    #2;
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_sof", m_sof, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    cycle();

    // S1: inputs 0 and 2 request; input 0 wins after reset, then 2.
    ob = out_log.size(); gb = grant_log.size();
    exp_out.delete(); exp_grants.delete();
    push(0, 32'hA0, 0); push(0, 32'hA1, 0); push(0, 32'hA2, 1);
    push(2, 32'hB0, 0); push(2, 32'hB1, 1);
    drive();
    cycle();
    #2;
    chk("s1_grant_vld", grant_vld, 1);
    chk("s1_grant_idx", grant_idx, 0);
    wait_done("s1", 50);
    exp_beat(1, 0, 32'hA0); exp_beat(0, 0, 32'hA1); exp_beat(0, 1, 32'hA2);
    exp_beat(1, 0, 32'hB0); exp_beat(0, 1, 32'hB1);
    exp_grants.push_back(0); exp_grants.push_back(2);
    check_logs("s1", ob, gb);

    // S2: all inputs request back-to-back 2-beat frames from reset.
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    ob = out_log.size(); gb = grant_log.size();
    exp_out.delete(); exp_grants.delete();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N_IN; i++) begin
        d = 32'h2000 + 32'(i * 16 + f * 4);
        push(i, d, 0);
        push(i, d + 1, 1);
      end
    drive();
    wait_done("s2", 100);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N_IN; i++) begin
        d = 32'h2000 + 32'(i * 16 + f * 4);
        exp_beat(1, 0, d);
        exp_beat(0, 1, d + 1);
        exp_grants.push_back(i);
      end
    check_logs("s2", ob, gb);
    if (out_cyc.size() > ob)
      chk("s2_span", out_cyc[out_cyc.size() - 1] - out_cyc[ob] + 1, 23);

    // S3: backpressure on the first beat of an input-1 frame.
    ob = out_log.size(); gb = grant_log.size(); sb = sof_cnt;
    exp_out.delete(); exp_grants.delete();
    push(1, 32'hD0, 0); push(1, 32'hD1, 0); push(1, 32'hD2, 1);
    drive();
    cycle();
    m_ready = 1'b0;
    cycle(); cycle();
    #2;
    chk("s3_cnt_stalled", beat_cnt, 0);
    chk("s3_sready_stalled", s_ready, 0);
    m_ready = 1'b1;
    cycle();
    #2;
    chk("s3_cnt_after", beat_cnt, 1);
    wait_done("s3", 50);
    chk("s3_sof_cycles", sof_cnt - sb, 3);
    exp_beat(1, 0, 32'hD0); exp_beat(0, 0, 32'hD1); exp_beat(0, 1, 32'hD2);
    exp_grants.push_back(1);
    check_logs("s3", ob, gb);

    // S4: single-beat frame on 2, then 0+3 contend with pointer at 2.
    ob = out_log.size(); gb = grant_log.size();
    exp_out.delete(); exp_grants.delete();
    push(2, 32'hE0, 1);
    push(0, 32'hF0, 1);
    push(3, 32'hC0, 0); push(3, 32'hC1, 1);
    drive();
    wait_done("s4", 50);
    exp_beat(1, 1, 32'hE0); exp_beat(1, 0, 32'hC0); exp_beat(0, 1, 32'hC1);
    exp_beat(1, 1, 32'hF0);
    exp_grants.push_back(2); exp_grants.push_back(3); exp_grants.push_back(0);
    check_logs("s4", ob, gb);

    // S5: mid-frame valid gap on input 0 while input 3 waits.
    ob = out_log.size(); gb = grant_log.size();
    exp_out.delete(); exp_grants.delete();
    push(0, 32'h10, 0); push(0, 32'h11, 0); push(0, 32'h12, 1);
    drive();
    cycle(); cycle();
    gap[0] = 1'b1;
    push(3, 32'h30, 1);
    drive();
    for (int n = 0; n < 5; n++) begin
      cycle();
      #2;
      chk("s5_grant_idx", grant_idx, 0);
      chk("s5_sready3", s_ready[3], 0);
    end
    gap[0] = 1'b0;
    drive();
    wait_done("s5", 50);
    exp_beat(1, 0, 32'h10); exp_beat(0, 0, 32'h11); exp_beat(0, 1, 32'h12);
    exp_beat(1, 1, 32'h30);
    exp_grants.push_back(0); exp_grants.push_back(3);
    check_logs("s5", ob, gb);

    // S6: reset during beat 2 of a 5-beat frame; pointer must restart.
    push(0, 32'h3F, 1);
    drive();
    wait_done("s6_pre", 20);
    for (int b = 0; b < 5; b++) push(1, 32'h40 + 32'(b), (b == 4));
    drive();
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    #2;
    chk("s6_m_valid", m_valid, 0);
    chk("s6_grant_vld", grant_vld, 0);
    chk("s6_beat_cnt", beat_cnt, 0);
    for (int i = 0; i < N_IN; i++) srcq[i].delete();
    drive();
    cycle();
    rst = 1'b0;
    ob = out_log.size(); gb = grant_log.size();
    exp_out.delete(); exp_grants.delete();
    push(0, 32'h50, 1);
    push(1, 32'h51, 1);
    drive();
    wait_done("s6", 50);
    exp_beat(1, 1, 32'h50); exp_beat(1, 1, 32'h51);
    exp_grants.push_back(0); exp_grants.push_back(1);
    check_logs("s6", ob, gb);

    cycle(); cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Round-robin arbiter that shares one AXI-Stream-style output (valid/ready/last/data) between N_IN frame sources.
- Grants per frame: once an input is granted, its whole frame (up to and including the beat with last) passes before any other input is considered.
- Sits upstream of shared packet consumers (DMA writer, framer). Exports grant index and an SOF pulse so downstream logic needs no separate frame-start detection.

Parameters:
- N_IN, 4, number of requesting inputs (2..16).
- DATA_W, 32, data width per beat.
- IDX_W, $clog2(N_IN), width of grant index (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  N_IN  per-input beat valid
- s_ready  out  N_IN  per-input beat ready
- s_last  in  N_IN  per-input end-of-frame marker
- s_data  in  N_IN*DATA_W  flattened data; input i occupies bits [i*DATA_W +: DATA_W]
- m_valid  out  1  output beat valid
- m_ready  in  1  output beat ready
- m_last  out  1  output end-of-frame
- m_data  out  DATA_W  output data
- grant_vld  out  1  high while a frame is locked to an input
- grant_idx  out  IDX_W  index of the locked input
- m_sof  out  1  high on the first beat of each output frame, while m_valid is high
- beat_cnt  out  16  beats accepted so far in the current frame; saturates at 16'hFFFF

Behaviour:
- Reset values: state=IDLE, grant_vld=0, grant_idx=0, m_valid=0, s_ready=0, m_sof=0, beat_cnt=0, rr_ptr=N_IN-1. With rr_ptr=N_IN-1, input 0 has top priority after reset.
- States: IDLE, LOCKED.
- IDLE:
  - s_ready=0 and m_valid=0.
  - If any s_valid is high, select the first i with s_valid[i]=1, searching i=rr_ptr+1, rr_ptr+2, … modulo N_IN.
  - Register grant_idx=i and grant_vld=1; go to LOCKED next cycle.
  - Arbitration latency is 1 cycle from valid to first possible output beat.
  - If no s_valid is high, stay in IDLE.
- LOCKED (g = grant_idx):
  - Combinational pass-through: m_valid=s_valid[g], m_last=s_last[g], m_data=s_data[g], s_ready[g]=m_ready.
  - s_ready[j]=0 for all j≠g.
  - No register stage in the data path; zero added latency.
- Beat accept: a beat is accepted when m_valid & m_ready.
  - On each accepted beat, beat_cnt increments (saturating).
- Frame end: an accepted beat with m_last=1 causes, next cycle:
  - state→IDLE, grant_vld=0, rr_ptr=g, beat_cnt=0.
  - grant_idx holds its last value.
  - Exactly one dead cycle follows between consecutive frames.
- m_sof = m_valid & first, where first is a flag set on entry to LOCKED and cleared after the first accepted beat.
  - m_sof stays high across backpressure stalls on the first beat.
  - A single-beat frame (first beat has last=1) gives m_sof=1 and m_last=1 on the same beat.
- Valid gaps inside a frame (s_valid[g] low mid-frame) keep the lock; other requesters wait.
- Requests from non-granted inputs during LOCKED are ignored. They are arbitrated in the next IDLE cycle using the updated rr_ptr.
- Source-side requirement: a source must not drop s_valid before acceptance (AXI rule). The arbiter does not check this.
- Simultaneous requests in IDLE are resolved purely by rr_ptr order. Fairness: an input that requests continuously is granted within N_IN frames.
- Reset mid-frame: the next cycle returns all outputs to reset values. The partial frame is abandoned with no flush and no last generated. Downstream must also be reset.
- N_IN not a power of two: rotation wraps at N_IN-1→0. grant_idx never exceeds N_IN-1.

Test Plan:
- Reset release, s_valid=4'b0101, input0 frame of 3 beats (data 0xA0..0xA2) → grant_idx=0 one cycle after valid; m_sof on 0xA0 only; m_last on 0xA2. Then one idle cycle, grant_idx=2.
- All four inputs valid continuously with 2-beat frames → grant order 0,1,2,3,0,… Each frame is 2 beats plus 1 dead cycle, giving throughput 2/3.
- Locked on input1, m_ready toggled 1,0,0,1 during the first beat → m_sof held high for 3 cycles; beat_cnt increments only on accepted cycles (0→1 after the 4th cycle); s_ready[1] mirrors m_ready.
- Input2 single-beat frame (last=1 on first beat) → m_sof=1 and m_last=1 on the same cycle; IDLE next cycle; rr_ptr=2, so an input0+input3 request grants 3 next.
- Locked on input0, s_valid[0] low for 5 cycles mid-frame while s_valid[3]=1 → no grant change, s_ready[3]=0 throughout; frame completes, then input3 is granted.
- Assert rst on beat 2 of a 5-beat frame → next cycle m_valid=0, grant_vld=0, beat_cnt=0. After release, input0 has priority again.
